led_pattern_gen: RTL

Parametrised LED/GPIO pattern generator for the iCEstick designs. A prescaler derives a step tick from CLK. Each tick advances one of four selectable patterns (binary count, bouncing scanner, PWM breathing, blink) across N_OUT outputs. It drives the on-board LEDs and J1/J2/J3 header pins from a single register bank.

---
 rtl/led_pattern_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// LED/GPIO pattern generator: a prescaled step tick drives one of four patterns
// (binary count, bouncing scanner, PWM breathing, blink) onto N_OUT outputs.
// Ports: CLK, RST (sync, active-high), en (run/hold), mode (requested pattern),
//        out (registered pattern), step_tick (1-cycle step pulse), mode_cur (active mode).
module led_pattern_gen #(
  parameter int N_OUT    = 8,
  parameter int DIV      = 22,
  parameter int PWM_BITS = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [N_OUT-1:0] out,
  output logic             step_tick,
  output logic [1:0]       mode_cur
);

  localparam int PW = (N_OUT > 2) ? $clog2(N_OUT) : 1;
  localparam logic [PW-1:0] POS_MAX = PW'(N_OUT - 1);
  localparam logic [PW-1:0] POS_ONE = PW'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
  localparam logic [N_OUT-1:0] ONE_HOT0 = N_OUT'(1);

  logic [DIV-1:0]      r_pre;
  logic [PWM_BITS-1:0] r_pwm;
  logic [N_OUT-1:0]    r_cnt;
  logic [PW-1:0]       r_pos;
  logic                r_dir;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_ddir;
  logic                r_blink;
  logic [1:0]          r_mode;
  logic [N_OUT-1:0]    r_out;
  logic                r_tick;

  logic                w_tick;
  logic [N_OUT-1:0]    w_cnt;
  logic [PW-1:0]       w_pos;
  logic                w_dir;
  logic [PWM_BITS-1:0] w_duty;
  logic                w_ddir;
  logic                w_blink;
  logic [1:0]          w_mode;
  logic [N_OUT-1:0]    w_out;

  assign out       = r_out;
  assign step_tick = r_tick;
  assign mode_cur  = r_mode;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pre   <= '0;
      r_pwm   <= '0;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_dir   <= 1'b0;
      r_duty  <= '0;
      r_ddir  <= 1'b0;
      r_blink <= 1'b0;
      r_mode  <= 2'd0;
      r_out   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_pwm   <= r_pwm + DUTY_ONE;
      if (en) r_pre <= r_pre + DIV'(1);
      r_cnt   <= w_cnt;
      r_pos   <= w_pos;
      r_dir   <= w_dir;
      r_duty  <= w_duty;
      r_ddir  <= w_ddir;
      r_blink <= w_blink;
      r_mode  <= w_mode;
      r_out   <= w_out;
      r_tick  <= w_tick;
    end
  end

  // dir/ddir: 0 = moving up, 1 = moving down
  always_comb begin
    w_tick  = en && (r_pre == '1);
    w_cnt   = r_cnt;
    w_pos   = r_pos;
    w_dir   = r_dir;
    w_duty  = r_duty;
    w_ddir  = r_ddir;
    w_blink = r_blink;
    w_mode  = r_mode;
    if (w_tick) begin
      if (mode != r_mode) begin
        // a switch consumes the tick: restart from reset state, no step
        w_mode  = mode;
        w_cnt   = '0;
        w_pos   = '0;
        w_dir   = 1'b0;
        w_duty  = '0;
        w_ddir  = 1'b0;
        w_blink = 1'b0;
      end else begin
        unique case (r_mode)
          2'd0: w_cnt = r_cnt + ONE_HOT0;
          2'd1: begin
            if (!r_dir) begin
              if (r_pos == POS_MAX) begin
                w_dir = 1'b1;
                w_pos = POS_MAX - POS_ONE;
              end else begin
                w_pos = r_pos + POS_ONE;
              end
            end else begin
              if (r_pos == '0) begin
                w_dir = 1'b0;
                w_pos = POS_ONE;
              end else begin
                w_pos = r_pos - POS_ONE;
              end
            end
          end
          2'd2: begin
            if (!r_ddir) begin
              if (r_duty == DUTY_MAX) begin
                w_ddir = 1'b1;
                w_duty = DUTY_MAX - DUTY_ONE;
              end else begin
                w_duty = r_duty + DUTY_ONE;
              end
            end else begin
              if (r_duty == '0) begin
                w_ddir = 1'b0;
                w_duty = DUTY_ONE;
              end else begin
                w_duty = r_duty - DUTY_ONE;
              end
            end
          end
          default: w_blink = ~r_blink;
        endcase
      end
    end
  end

  // decode the current (pre-update) state; out lags state by one cycle
  always_comb begin
    w_out = '0;
    unique case (r_mode)
      2'd0: w_out = r_cnt;
      2'd1: w_out = ONE_HOT0 << r_pos;
      2'd2: w_out = {N_OUT{r_pwm < r_duty}};
      default: w_out = {N_OUT{r_blink}};
    endcase
  end

endmodule
